// File: rtl/shifter_sequential.sv
// rtl/shifter_sequential.sv - sequential one-bit-per-cycle 32-bit shifter with lost-bit flag
module shifter_sequential (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        sh_dir,
  input  logic        neg,
  input  logic [4:0]  amt,
  input  logic [31:0] operand,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        lost
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        dir_q;
  logic        neg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (amt != 5'd0) ? SHIFT : FINISH;
      SHIFT:   if (abort) state_nxt = IDLE;
               else if (cnt == 5'd1) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An aborted cycle performs no shift, so the partial result stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= 32'h0000_0000;
      cnt    <= 5'd0;
      dir_q  <= 1'b0;
      neg_q  <= 1'b0;
      lost   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          result <= operand;
          cnt    <= amt;
          dir_q  <= sh_dir;
          neg_q  <= neg;
          lost   <= 1'b0;
        end
        SHIFT: if (!abort) begin
          cnt <= cnt - 5'd1;
          if (dir_q) begin
            result <= {neg_q, result[31:1]};
            lost   <= lost | result[0];
          end else begin
            result <= {result[30:0], 1'b0};
            lost   <= lost | result[31];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == FINISH);

endmodule

// File: doc/shifter_sequential.md
SHIFTER_SEQUENTIAL -- requirements
Module: Shifter_Sequential

Interface
REQ-001 Parameters: none; the datapath width SHALL be fixed at 32 bits.
REQ-002 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 RESET  input  1  reset, asynchronous and active-high.
REQ-004 START  input  1  request pulse; sampled only in IDLE.
REQ-005 ABORT  input  1  cancels an operation in progress.
REQ-006 SH_DIR  input  1  1 = right shift, 0 = left shift; captured at START.
REQ-007 NEG  input  1  fill bit for right shifts (1 = fill MSB with 1); captured at START.
REQ-008 AMT  input  5  shift amount, 0..31; captured at START.
REQ-009 INPUT  input  32  operand; captured at START.
REQ-010 OUTPUT  output  32  result register.
REQ-011 BUSY  output  1  high while in SHIFT.
REQ-012 DONE  output  1  one-cycle completion pulse.
REQ-013 LOST  output  1  1 if any shifted-out bit was 1; valid with DONE and held until the next accepted START.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, FINISH.
REQ-015 IDLE with START=1: the block SHALL load INPUT into OUTPUT, load AMT into a 5-bit counter, latch SH_DIR and NEG, clear LOST, and go to SHIFT if AMT!=0, else go to FINISH.
REQ-016 IDLE with START=0: the block SHALL hold all registers.
REQ-017 SHIFT: each cycle the block SHALL shift OUTPUT by exactly one bit and decrement the counter.
- Left shift: bit0 gets 0.
- Right shift: bit31 gets the latched NEG.
REQ-018 SHIFT: LOST SHALL be ORed each cycle with the bit leaving the register (bit31 for left, bit0 for right).
REQ-019 SHIFT with counter==1: the block SHALL perform the final shift and go to FINISH.
REQ-020 FINISH: the block SHALL assert DONE for exactly one cycle and return to IDLE.
REQ-021 Latency: DONE SHALL assert AMT+1 cycles after the START edge for AMT>=1, and 1 cycle after it for AMT=0.
REQ-022 BUSY SHALL equal (state==SHIFT); DONE SHALL equal (state==FINISH).
REQ-023 START while in SHIFT or FINISH SHALL be ignored and not queued.
REQ-024 ABORT in SHIFT SHALL return the block to IDLE on the next edge with no DONE pulse; OUTPUT and LOST SHALL keep their partially shifted values.
REQ-025 ABORT in IDLE or FINISH SHALL have no effect; ABORT and START together in IDLE: START SHALL win.
REQ-026 Changes to SH_DIR, NEG, AMT or INPUT after the START edge SHALL NOT affect the operation in progress.
REQ-027 OUTPUT SHALL hold the final result in IDLE until the next accepted START.
REQ-028 The result SHALL equal INPUT<<AMT (left), or INPUT>>AMT with the top AMT bits set to NEG (right).

Reset
REQ-029 RESET=1 SHALL immediately force:
- state = IDLE
- OUTPUT = 32'h0000_0000
- counter = 0
- BUSY = 0, DONE = 0, LOST = 0
- latched SH_DIR = 0, latched NEG = 0
REQ-030 RESET asserted mid-SHIFT SHALL abandon the operation with no DONE pulse.
REQ-031 The first START SHALL be accepted on the first rising edge after RESET deasserts.

Verification
REQ-032 Left shift: INPUT=32'h8000_0001, AMT=4, SH_DIR=0 -> DONE at cycle 5, OUTPUT=32'h0000_0010, LOST=1.
REQ-033 Right shift: INPUT=32'hF000_0000, AMT=8, SH_DIR=1, NEG=1 -> DONE at cycle 9, OUTPUT=32'hFFF0_0000, LOST=0.
REQ-034 Zero amount: AMT=0, INPUT=32'h1234_5678 -> DONE at cycle 1, BUSY never high, OUTPUT=32'h1234_5678, LOST=0.
REQ-035 Maximum amount: AMT=31, SH_DIR=1, NEG=0, INPUT=32'hFFFF_FFFF -> DONE at cycle 32, OUTPUT=32'h0000_0001, LOST=1.
REQ-036 Interference: START re-pulsed with new operands during SHIFT -> ignored, first result unchanged; ABORT at cycle 3 of AMT=10 -> IDLE, no DONE.
REQ-037 Reset mid-operation: RESET at cycle 2 of AMT=6 -> OUTPUT=0, BUSY=0, no DONE; a new START 1 cycle after release completes correctly.
